// File: rtl/issue_scoreboard_pkg.sv
// Shared defaults and constants for the in-order issue scoreboard.
// Register count, writeback latency and the stall counter width live here.
package issue_scoreboard_pkg;

  localparam int DEF_NREG    = 4;
  localparam int DEF_REGNO_W = 2;
  localparam int DEF_WB_LAT  = 3;
  localparam int DEF_BYPASS  = 1;

  localparam int                     STALL_CNT_W   = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/issue_scoreboard_wb_pipe.sv
// Fixed-latency writeback pipe: a DEPTH-deep shift register of {valid, regno}.
// It advances every cycle and is never held by issue stalls.
module issue_scoreboard_wb_pipe
  import issue_scoreboard_pkg::*;
#(
  parameter int DEPTH   = DEF_WB_LAT,
  parameter int REGNO_W = DEF_REGNO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [REGNO_W-1:0] in_regno,
  output logic               out_valid,
  output logic [REGNO_W-1:0] out_regno
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [REGNO_W-1:0] regno_q [DEPTH];
  logic [REGNO_W-1:0] regno_d [DEPTH];

  // NOTE: every variable gets a value at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d    = valid_q;
    regno_d    = regno_q;
    valid_d[0] = in_valid;
    regno_d[0] = in_regno;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      regno_d[i] = regno_q[i-1];
    end
  end

  // NOTE: state is updated with <= so every stage samples the pre-edge value of the stage before it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      // NOTE: the regno storage is reset as well, so wb_regno reads 0 after reset instead of stale data.
      for (int i = 0; i < DEPTH; i++) regno_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      regno_q <= regno_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_regno = regno_q[DEPTH-1];

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: per-register write reservations, RAW/WAW hazard stall,
// reserve/read strobes at issue and fixed-latency writeback sequencing.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG    = DEF_NREG,
  parameter int REGNO_W = DEF_REGNO_W,
  parameter int WB_LAT  = DEF_WB_LAT,
  parameter int BYPASS  = DEF_BYPASS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [REGNO_W-1:0]     dec_rs,
  input  logic                   dec_rs_use,
  input  logic [REGNO_W-1:0]     dec_rt,
  input  logic                   dec_rt_use,
  input  logic [REGNO_W-1:0]     dec_rd,
  input  logic                   dec_rd_we,
  input  logic                   ext_stall,
  output logic                   issue,
  output logic                   stall_insnfetch,
  output logic [NREG-1:0]        w_reserve,
  output logic [NREG-1:0]        rs_exp,
  output logic                   is_wb,
  output logic [REGNO_W-1:0]     wb_regno,
  output logic [NREG-1:0]        wb_exp,
  output logic [NREG-1:0]        reserved,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [NREG-1:0]        reserved_q, reserved_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic                   pipe_push;
  logic [REGNO_W-1:0]     pipe_regno;
  logic                   pipe_out_valid;
  logic [REGNO_W-1:0]     pipe_out_regno;

  logic [NREG-1:0]        wb_exp_c;
  logic [NREG-1:0]        hazard_vec;
  logic                   raw_c, waw_c, issue_c, stall_c;
  logic [NREG-1:0]        rs_exp_c, w_reserve_c;

  function automatic logic [NREG-1:0] onehot(input logic [REGNO_W-1:0] regno);
    onehot        = '0;
    onehot[regno] = 1'b1;
  endfunction

  always_comb begin
    wb_exp_c = pipe_out_valid ? onehot(pipe_out_regno) : '0;

    // A reservation retiring this cycle can be bypassed to the consumer.
    hazard_vec = (BYPASS != 0) ? (reserved_q & ~wb_exp_c) : reserved_q;

    raw_c   = (dec_rs_use & hazard_vec[dec_rs]) | (dec_rt_use & hazard_vec[dec_rt]);
    waw_c   = dec_rd_we & hazard_vec[dec_rd];
    issue_c = rst & dec_valid & ~raw_c & ~waw_c & ~ext_stall;
    stall_c = rst & dec_valid & ~issue_c;

    rs_exp_c = '0;
    if (issue_c) begin
      if (dec_rs_use) rs_exp_c = rs_exp_c | onehot(dec_rs);
      if (dec_rt_use) rs_exp_c = rs_exp_c | onehot(dec_rt);
    end
    w_reserve_c = (issue_c && dec_rd_we) ? onehot(dec_rd) : '0;

    pipe_push  = issue_c & dec_rd_we;
    pipe_regno = pipe_push ? dec_rd : '0;

    // Clear first, then set: a same-register re-reservation wins over its retirement.
    reserved_d = (reserved_q & ~wb_exp_c) | w_reserve_c;

    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reserved_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      reserved_q  <= reserved_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  issue_scoreboard_wb_pipe #(
    .DEPTH   (WB_LAT),
    .REGNO_W (REGNO_W)
  ) u_wb_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pipe_push),
    .in_regno  (pipe_regno),
    .out_valid (pipe_out_valid),
    .out_regno (pipe_out_regno)
  );

  assign issue           = issue_c;
  assign stall_insnfetch = stall_c;
  assign w_reserve       = w_reserve_c;
  assign rs_exp          = rs_exp_c;
  assign is_wb           = pipe_out_valid;
  assign wb_regno        = pipe_out_regno;
  assign wb_exp          = wb_exp_c;
  assign reserved        = reserved_q;
  assign stall_cnt       = stall_cnt_q;

endmodule
